dl_stream_loader: RTL and testbench

- Byte-stream download writer. Produces the DL_ADDR/DL_WR/DL_DATA write bus that fills the game ROM/RAM images, including the star table at 0xF800-0xFFFF.
- Accepts framed packets from the host byte stream over a valid/ready handshake.
- Emits one write strobe per data byte.
- Holds O_BUSY so the top level can keep the game CPU in reset while a load is in progress.

---
 rtl/dl_stream_loader.sv | 276 +++++++++++++++++++++++++++
 tb/tb_dl_stream_loader.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dl_stream_loader.sv
// Byte-stream download writer: turns framed host packets into DL_ADDR/DL_DATA/DL_WR writes.
// Optional trailing checksum byte is enabled by defining DL_CHECKSUM_EN.
module dl_stream_loader #(
    parameter int unsigned WR_GAP  = 1,
    parameter int unsigned TIMEOUT = 24000000,
    parameter logic [7:0]  SYNC    = 8'hA5
) (
    input  logic        CLK_24M,
    input  logic        RESETn,
    input  logic [7:0]  I_DATA,
    input  logic        I_VALID,
    output logic        O_READY,
    output logic [15:0] DL_ADDR,
    output logic [7:0]  DL_DATA,
    output logic        DL_WR,
    output logic        O_BUSY,
    output logic        O_DONE,
    output logic        O_ERR
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_AH   = 4'd1,
        S_AL   = 4'd2,
        S_LH   = 4'd3,
        S_LL   = 4'd4,
        S_DATA = 4'd5,
        S_WR   = 4'd6,
        S_GAP  = 4'd7,
        S_FIN  = 4'd8
`ifdef DL_CHECKSUM_EN
        ,
        S_CK   = 4'd9
`endif
    } state_t;

`ifdef DL_CHECKSUM_EN
    localparam state_t S_END = S_CK;
`else
    localparam state_t S_END = S_FIN;
`endif

    localparam logic [31:0] TO_LIM   = 32'(TIMEOUT);
    localparam logic        TO_EN    = (TIMEOUT != 32'd0);
    localparam logic        GAP_ZERO = (WR_GAP == 32'd0);
    localparam logic [3:0]  GAP_LAST = 4'(WR_GAP - 32'd1);

    function automatic logic ready_of(input state_t s);
        case (s)
            S_IDLE, S_AH, S_AL, S_LH, S_LL, S_DATA: ready_of = 1'b1;
`ifdef DL_CHECKSUM_EN
            S_CK:                                   ready_of = 1'b1;
`endif
            default:                                ready_of = 1'b0;
        endcase
    endfunction

    // States in which a stalled host counts towards the abort timeout.
    function automatic logic is_counted(input state_t s);
        case (s)
            S_AH, S_AL, S_LH, S_LL, S_DATA: is_counted = 1'b1;
`ifdef DL_CHECKSUM_EN
            S_CK:                           is_counted = 1'b1;
`endif
            default:                        is_counted = 1'b0;
        endcase
    endfunction

`ifdef DL_CHECKSUM_EN
    function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] b);
        sum8 = acc + b;
    endfunction

    logic [7:0]  sum_q, sum_d;
`endif

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  len_hi_q, len_hi_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  gap_q, gap_d;
    logic [31:0] to_q, to_d;
    logic        err_q, err_d;
    logic [15:0] dl_addr_q, dl_addr_d;
    logic [7:0]  dl_data_q, dl_data_d;
    logic        ready_q, busy_q, done_q, wr_q;
    logic        xfer_s, to_hit_s;

    assign xfer_s   = I_VALID & ready_q;
    assign to_hit_s = TO_EN & is_counted(state_q) & ~xfer_s & (to_q == (TO_LIM - 32'd1));

    // Next-state, datapath and timeout logic.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_hi_d  = len_hi_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        err_d     = err_q;
        dl_addr_d = dl_addr_q;
        dl_data_d = dl_data_q;
`ifdef DL_CHECKSUM_EN
        sum_d     = sum_q;
`endif
        if (TO_EN && is_counted(state_q) && !xfer_s) begin
            to_d = to_q + 32'd1;
        end else begin
            to_d = 32'd0;
        end

        case (state_q)
            S_IDLE: begin
                if (xfer_s && (I_DATA == SYNC)) begin
                    state_d = S_AH;
                    err_d   = 1'b0;
`ifdef DL_CHECKSUM_EN
                    sum_d   = 8'd0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_AH: begin
                if (xfer_s) begin
                    addr_d[15:8] = I_DATA;
                    state_d      = S_AL;
`ifdef DL_CHECKSUM_EN
                    sum_d        = sum8(sum_q, I_DATA);
`endif
                end else begin
                    state_d = S_AH;
                end
            end
            S_AL: begin
                if (xfer_s) begin
                    addr_d[7:0] = I_DATA;
                    state_d     = S_LH;
`ifdef DL_CHECKSUM_EN
                    sum_d       = sum8(sum_q, I_DATA);
`endif
                end else begin
                    state_d = S_AL;
                end
            end
            S_LH: begin
                if (xfer_s) begin
                    len_hi_d = I_DATA;
                    state_d  = S_LL;
`ifdef DL_CHECKSUM_EN
                    sum_d    = sum8(sum_q, I_DATA);
`endif
                end else begin
                    state_d = S_LH;
                end
            end
            S_LL: begin
                if (xfer_s) begin
                    cnt_d   = {len_hi_q, I_DATA};
                    state_d = ({len_hi_q, I_DATA} == 16'd0) ? S_END : S_DATA;
`ifdef DL_CHECKSUM_EN
                    sum_d   = sum8(sum_q, I_DATA);
`endif
                end else begin
                    state_d = S_LL;
                end
            end
            S_DATA: begin
                if (xfer_s) begin
                    dl_addr_d = addr_q;
                    dl_data_d = I_DATA;
                    state_d   = S_WR;
`ifdef DL_CHECKSUM_EN
                    sum_d     = sum8(sum_q, I_DATA);
`endif
                end else begin
                    state_d = S_DATA;
                end
            end
            S_WR: begin
                addr_d = addr_q + 16'd1;
                cnt_d  = cnt_q - 16'd1;
                gap_d  = 4'd0;
                if (cnt_q == 16'd1) begin
                    state_d = S_END;
                end else if (GAP_ZERO) begin
                    state_d = S_DATA;
                end else begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_DATA;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
`ifdef DL_CHECKSUM_EN
            S_CK: begin
                if (xfer_s) begin
                    if (sum8(sum_q, I_DATA) == 8'd0) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end
                end else begin
                    state_d = S_CK;
                end
            end
`endif
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A stalled host abandons the packet; writes already issued stay.
        if (to_hit_s) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
        end else begin
            err_d = err_d;
        end
    end

    // State, datapath and registered output flops.
    always_ff @(posedge CLK_24M or negedge RESETn) begin
        if (!RESETn) begin
            state_q   <= S_IDLE;
            addr_q    <= 16'd0;
            len_hi_q  <= 8'd0;
            cnt_q     <= 16'd0;
            gap_q     <= 4'd0;
            to_q      <= 32'd0;
            err_q     <= 1'b0;
            dl_addr_q <= 16'd0;
            dl_data_q <= 8'd0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_q      <= 1'b0;
`ifdef DL_CHECKSUM_EN
            sum_q     <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_hi_q  <= len_hi_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            to_q      <= to_d;
            err_q     <= err_d;
            dl_addr_q <= dl_addr_d;
            dl_data_q <= dl_data_d;
            ready_q   <= ready_of(state_d);
            busy_q    <= (state_d != S_IDLE);
            done_q    <= (state_d == S_FIN);
            wr_q      <= (state_d == S_WR);
`ifdef DL_CHECKSUM_EN
            sum_q     <= sum_d;
`endif
        end
    end

    assign O_READY = ready_q;
    assign DL_ADDR = dl_addr_q;
    assign DL_DATA = dl_data_q;
    assign DL_WR   = wr_q;
    assign O_BUSY  = busy_q;
    assign O_DONE  = done_q;
    assign O_ERR   = err_q;

endmodule

// File: tb/tb_dl_stream_loader.sv
// Scoreboard bench for dl_stream_loader: expected writes/done pulses are queued by the
// stimulus and consumed by an independent monitor; define DL_CHECKSUM_EN to cover the checksum.
module tb_dl_stream_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  i_data;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] dl_addr;
    logic [7:0]  dl_data;
    logic        dl_wr;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    always #5 clk = ~clk;

    dl_stream_loader #(.WR_GAP(1), .TIMEOUT(100), .SYNC(8'hA5)) dut (
        .CLK_24M(clk),
        .RESETn (rst_n),
        .I_DATA (i_data),
        .I_VALID(i_valid),
        .O_READY(o_ready),
        .DL_ADDR(dl_addr),
        .DL_DATA(dl_data),
        .DL_WR  (dl_wr),
        .O_BUSY (o_busy),
        .O_DONE (o_done),
        .O_ERR  (o_err)
    );

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t         exp_wr[$];
    int          exp_done[$];
    logic [7:0]  pkt[$];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_wr(input logic [15:0] a, input logic [7:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        exp_wr.push_back(w);
    endtask

    // Monitor: every write strobe and done pulse must match the head of its queue.
    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (dl_wr) begin
                    if (exp_wr.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL wr_unexpected: got write %0h=%0h, expected none", dl_addr, dl_data);
                    end else begin
                        w = exp_wr.pop_front();
                        check("wr_addr", 32'(dl_addr), 32'(w.a));
                        check("wr_data", 32'(dl_data), 32'(w.d));
                    end
                end
                if (o_done) begin
                    if (exp_done.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL done_unexpected: got O_DONE=1, expected 0");
                    end else begin
                        check("done_pulse", 32'(o_done), 32'(exp_done.pop_front()));
                    end
                end
            end
        end
    end

    // Called at posedge+1; returns with the byte transferred and time at posedge+1.
    task automatic send_byte(input logic [7:0] b, output int waits);
        waits   = 0;
        i_data  = b;
        i_valid = 1'b1;
        while (!o_ready && waits < 64) begin
            @(posedge clk);
            #1;
            waits++;
        end
        if (!o_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL ready_timeout: got O_READY=0 for %0d cycles, expected 1", waits);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input int ndata, input bit gap_chk);
        int w;
        for (int i = 0; i < pkt.size(); i++) begin
            send_byte(pkt[i], w);
            if (gap_chk && i >= 6 && i < 5 + ndata) check("ready_gap", 32'(w), 32'd2);
            if (i >= 5 && i < 5 + ndata) check("wr_latency", 32'(dl_wr), 32'd1);
        end
    endtask

    task automatic add_chk();
`ifdef DL_CHECKSUM_EN
        logic [7:0] s;
        s = 8'd0;
        for (int i = 1; i < pkt.size(); i++) s = s + pkt[i];
        pkt.push_back(8'd0 - s);
`endif
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!o_done && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("done_seen", 32'(o_done), 32'd1);
        check("done_busy", 32'(o_busy), 32'd1);
        check("done_ready", 32'(o_ready), 32'd0);
        @(posedge clk);
        #1;
        check("busy_fall", 32'(o_busy), 32'd0);
        check("ready_idle", 32'(o_ready), 32'd1);
    endtask

    initial begin
        int w;
        int k;
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(o_ready), 32'd0);
        check("rst_addr", 32'(dl_addr), 32'd0);
        check("rst_data", 32'(dl_data), 32'd0);
        check("rst_wr", 32'(dl_wr), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done_err", 32'({o_done, o_err}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_ready", 32'(o_ready), 32'd1);

        // Basic load into the star table.
        pkt = '{8'hA5, 8'hF8, 8'h00, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
        add_chk();
        push_wr(16'hF800, 8'h11);
        push_wr(16'hF801, 8'h22);
        push_wr(16'hF802, 8'h33);
        exp_done.push_back(1);
        send_pkt(3, 1'b1);
        i_valid = 1'b0;
        wait_done();
        idle(2);

        // Garbage ahead of sync is discarded.
        send_byte(8'h00, w);
        check("garbage_busy0", 32'(o_busy), 32'd0);
        send_byte(8'hFF, w);
        check("garbage_busy1", 32'(o_busy), 32'd0);
        send_byte(8'h5A, w);
        check("garbage_busy2", 32'(o_busy), 32'd0);
        pkt = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h01, 8'h7E};
        add_chk();
        push_wr(16'h0010, 8'h7E);
        exp_done.push_back(1);
        send_pkt(1, 1'b0);
        i_valid = 1'b0;
        wait_done();
        idle(2);

        // Zero length: done with no write, bus holds.
        pkt = '{8'hA5, 8'h12, 8'h34, 8'h00, 8'h00};
        add_chk();
        exp_done.push_back(1);
        send_pkt(0, 1'b0);
        i_valid = 1'b0;
        wait_done();
        check("zl_addr_hold", 32'(dl_addr), 32'h0010);
        check("zl_data_hold", 32'(dl_data), 32'h7E);
        idle(2);

        // Address wrap-around.
        pkt = '{8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'hAA, 8'hBB};
        add_chk();
        push_wr(16'hFFFF, 8'hAA);
        push_wr(16'h0000, 8'hBB);
        exp_done.push_back(1);
        send_pkt(2, 1'b1);
        i_valid = 1'b0;
        wait_done();
        check("wrap_err", 32'(o_err), 32'd0);
        idle(2);

        // Timeout mid-packet.
        pkt = '{8'hA5, 8'hF8, 8'h00, 8'h00, 8'h04, 8'h01, 8'h02};
        push_wr(16'hF800, 8'h01);
        push_wr(16'hF801, 8'h02);
        send_pkt(2, 1'b1);
        i_valid = 1'b0;
        k = 0;
        while (!o_err && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("to_err", 32'(o_err), 32'd1);
        check("to_busy", 32'(o_busy), 32'd0);
        check("to_ready", 32'(o_ready), 32'd1);
        idle(3);
        check("to_err_sticky", 32'(o_err), 32'd1);
        send_byte(8'hA5, w);
        check("sync_clears_err", 32'(o_err), 32'd0);
        pkt = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
        add_chk();
        pkt.delete(0);
        exp_done.push_back(1);
        for (int i = 0; i < pkt.size(); i++) send_byte(pkt[i], w);
        i_valid = 1'b0;
        wait_done();
        idle(2);

`ifdef DL_CHECKSUM_EN
        // Good then bad checksum.
        pkt = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h01, 8'h05, 8'hFA};
        push_wr(16'h0000, 8'h05);
        exp_done.push_back(1);
        send_pkt(1, 1'b0);
        i_valid = 1'b0;
        wait_done();
        check("ck_good_err", 32'(o_err), 32'd0);
        idle(2);
        pkt = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h01, 8'h05, 8'hFB};
        push_wr(16'h0000, 8'h05);
        send_pkt(1, 1'b0);
        i_valid = 1'b0;
        check("ck_bad_err", 32'(o_err), 32'd1);
        check("ck_bad_busy", 32'(o_busy), 32'd0);
        idle(4);
`endif

        // Reset asserted during a write strobe.
        pkt = '{8'hA5, 8'h12, 8'h00, 8'h00, 8'h02, 8'h77};
        for (int i = 0; i < pkt.size(); i++) send_byte(pkt[i], w);
        check("mid_wr_active", 32'(dl_wr), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_wr", 32'(dl_wr), 32'd0);
        check("mid_rst_ready", 32'(o_ready), 32'd0);
        check("mid_rst_busy", 32'(o_busy), 32'd0);
        check("mid_rst_addr", 32'(dl_addr), 32'd0);
        i_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", 32'(o_ready), 32'd1);
        check("post_rst_busy", 32'(o_busy), 32'd0);
        pkt = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h01, 8'h99};
        add_chk();
        push_wr(16'h0020, 8'h99);
        exp_done.push_back(1);
        send_pkt(1, 1'b0);
        i_valid = 1'b0;
        wait_done();
        idle(3);

        check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        check("done_queue_empty", 32'(exp_done.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
